// File: rtl/serial_init_port.sv
// Serial bus initiator: accepts read/write burst requests, arbitrates for
// the shared bus, shifts the address and write data out LSB-first, collects
// read data LSB-first, waits for the target acknowledge and supports split
// transactions that are resumed exactly where they stopped.
module serial_init_port #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 255,
   localparam int LEN_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              err,
   output logic              split,
   output logic              busy,
   output logic              arb_req,
   input  logic              arb_grant,
   output logic              bus_out,
   output logic              bus_out_valid,
   output logic              bus_mode,
   output logic              bus_rw,
   input  logic              bus_in,
   input  logic              bus_in_valid,
   input  logic              tgt_ack,
   input  logic              tgt_split
);

   localparam int ABIT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
   localparam int DBIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int IDX_W  = (ABIT_W > DBIT_W) ? ABIT_W : DBIT_W;
   localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_W - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      ADDR,
      WDATA,
      RDATA,
      ACK,
      SPLIT
   } state_t;

   state_t              state, state_n;
   state_t              saved_state, saved_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic                rw_q, rw_n;
   logic [LEN_W-1:0]    len_q, len_n;
   logic [LEN_W-1:0]    beat_q, beat_n;
   logic [IDX_W-1:0]    bit_q, bit_n, bit_inc;
   logic [DATA_W-1:0]   shift_q, shift_n;
   logic [WD_W-1:0]     wd_q, wd_n;

   logic                req_ready_n, wdata_ready_n, rdata_valid_n;
   logic                done_n, err_n, split_n, busy_n, arb_req_n;
   logic                bus_out_n, bus_out_valid_n, bus_mode_n, bus_rw_n;
   logic [DATA_W-1:0]   rdata_n;
   logic                capture, abort, timeout;

   assign bit_inc = bit_q + 1'b1;

   // State, datapath and every output are flops; rst_n clears them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         saved_state   <= IDLE;
         addr_q        <= '0;
         rw_q          <= 1'b0;
         len_q         <= '0;
         beat_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         wd_q          <= '0;
         req_ready     <= 1'b1;
         wdata_ready   <= 1'b0;
         rdata         <= '0;
         rdata_valid   <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         split         <= 1'b0;
         busy          <= 1'b0;
         arb_req       <= 1'b0;
         bus_out       <= 1'b0;
         bus_out_valid <= 1'b0;
         bus_mode      <= 1'b0;
         bus_rw        <= 1'b0;
      end else begin
         state         <= state_n;
         saved_state   <= saved_n;
         addr_q        <= addr_n;
         rw_q          <= rw_n;
         len_q         <= len_n;
         beat_q        <= beat_n;
         bit_q         <= bit_n;
         shift_q       <= shift_n;
         wd_q          <= wd_n;
         req_ready     <= req_ready_n;
         wdata_ready   <= wdata_ready_n;
         rdata         <= rdata_n;
         rdata_valid   <= rdata_valid_n;
         done          <= done_n;
         err           <= err_n;
         split         <= split_n;
         busy          <= busy_n;
         arb_req       <= arb_req_n;
         bus_out       <= bus_out_n;
         bus_out_valid <= bus_out_valid_n;
         bus_mode      <= bus_mode_n;
         bus_rw        <= bus_rw_n;
      end
   end

   // Next-state and next-output decode; pulses default low, levels hold.
   always_comb begin
      state_n         = state;
      saved_n         = saved_state;
      addr_n          = addr_q;
      rw_n            = rw_q;
      len_n           = len_q;
      beat_n          = beat_q;
      bit_n           = bit_q;
      shift_n         = shift_q;
      wd_n            = wd_q;
      req_ready_n     = req_ready;
      busy_n          = busy;
      arb_req_n       = arb_req;
      split_n         = split;
      bus_mode_n      = bus_mode;
      bus_rw_n        = bus_rw;
      rdata_n         = rdata;
      bus_out_n       = 1'b0;
      bus_out_valid_n = 1'b0;
      wdata_ready_n   = 1'b0;
      rdata_valid_n   = 1'b0;
      done_n          = 1'b0;
      err_n           = 1'b0;
      capture         = 1'b0;
      abort           = 1'b0;
      timeout         = 1'b0;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_n      = req_addr;
               rw_n        = req_rw;
               len_n       = req_len;
               bus_rw_n    = req_rw;
               req_ready_n = 1'b0;
               busy_n      = 1'b1;
               arb_req_n   = 1'b1;
               state_n     = ARB;
            end
         end

         ARB: begin
            if (arb_grant) begin
               state_n         = ADDR;
               bit_n           = '0;
               bus_out_n       = addr_q[0];
               bus_out_valid_n = 1'b1;
               bus_mode_n      = 1'b0;
            end
         end

         ADDR: begin
            if (!arb_grant) begin
               abort = 1'b1;
            end else if (bit_q == ADDR_LAST) begin
               beat_n     = '0;
               bit_n      = '0;
               bus_mode_n = 1'b1;
               if (rw_q) begin
                  state_n = WDATA;
                  capture = 1'b1;
               end else begin
                  state_n = RDATA;
                  shift_n = '0;
                  wd_n    = '0;
               end
            end else begin
               bit_n           = bit_inc;
               bus_out_n       = addr_q[bit_inc[ABIT_W-1:0]];
               bus_out_valid_n = 1'b1;
            end
         end

         WDATA: begin
            // bus_out_valid doubles as the "shifter holds a word" flag here.
            if (!arb_grant) begin
               abort = 1'b1;
            end else if (bus_out_valid) begin
               if (bit_q == DATA_LAST) begin
                  if (beat_q == len_q) begin
                     state_n    = ACK;
                     bus_mode_n = 1'b0;
                     wd_n       = '0;
                  end else begin
                     beat_n  = beat_q + 1'b1;
                     bit_n   = '0;
                     capture = 1'b1;
                  end
               end else begin
                  bit_n           = bit_inc;
                  bus_out_n       = shift_q[bit_inc[DBIT_W-1:0]];
                  bus_out_valid_n = 1'b1;
               end
            end else begin
               capture = 1'b1;
            end
         end

         RDATA: begin
            if (tgt_split) begin
               saved_n    = RDATA;
               state_n    = SPLIT;
               split_n    = 1'b1;
               arb_req_n  = 1'b0;
               bus_mode_n = 1'b0;
            end else if (bus_in_valid) begin
               wd_n = '0;
               shift_n[bit_q[DBIT_W-1:0]] = bus_in;
               if (bit_q == DATA_LAST) begin
                  rdata_n       = shift_n;
                  rdata_valid_n = 1'b1;
                  shift_n       = '0;
                  bit_n         = '0;
                  if (beat_q == len_q) begin
                     state_n    = ACK;
                     bus_mode_n = 1'b0;
                  end else begin
                     beat_n = beat_q + 1'b1;
                  end
               end else begin
                  bit_n = bit_inc;
               end
            end else if (wd_q == WD_LAST) begin
               timeout = 1'b1;
            end else begin
               wd_n = wd_q + 1'b1;
            end
         end

         ACK: begin
            if (tgt_ack) begin
               done_n      = 1'b1;
               state_n     = IDLE;
               req_ready_n = 1'b1;
               busy_n      = 1'b0;
               arb_req_n   = 1'b0;
               bus_rw_n    = 1'b0;
            end else if (tgt_split) begin
               saved_n   = ACK;
               state_n   = SPLIT;
               split_n   = 1'b1;
               arb_req_n = 1'b0;
            end else if (wd_q == WD_LAST) begin
               timeout = 1'b1;
            end else begin
               wd_n = wd_q + 1'b1;
            end
         end

         SPLIT: begin
            // First wait for the target to release, then re-arbitrate.
            if (!arb_req) begin
               if (!tgt_split) begin
                  arb_req_n = 1'b1;
               end
            end else if (arb_grant) begin
               state_n    = saved_state;
               split_n    = 1'b0;
               wd_n       = '0;
               bus_mode_n = (saved_state == RDATA);
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      if (capture && wdata_valid) begin
         shift_n         = wdata;
         bus_out_n       = wdata[0];
         bus_out_valid_n = 1'b1;
         wdata_ready_n   = 1'b1;
      end

      if (abort || timeout) begin
         err_n           = 1'b1;
         state_n         = IDLE;
         req_ready_n     = 1'b1;
         busy_n          = 1'b0;
         arb_req_n       = 1'b0;
         split_n         = 1'b0;
         bus_out_n       = 1'b0;
         bus_out_valid_n = 1'b0;
         bus_mode_n      = 1'b0;
         bus_rw_n        = 1'b0;
         wdata_ready_n   = 1'b0;
         rdata_valid_n   = 1'b0;
         shift_n         = '0;
         bit_n           = '0;
         beat_n          = '0;
         wd_n            = '0;
      end
   end

endmodule

// File: doc/serial_init_port.md
SERIAL_INIT_PORT -- requirements
Module: serial_init_port

Interface
REQ-001 Parameters SHALL be: ADDR_W default 16, address bits; DATA_W default 8, data bits per beat; MAX_BURST default 4, max beats per transaction; TIMEOUT default 255, cycles waiting for target before error.
REQ-002 Ports SHALL be: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 Request ports SHALL be: req_valid in 1; req_ready out 1; req_rw in 1, 1=write 0=read; req_addr in ADDR_W; req_len in clog2(MAX_BURST), beats minus 1.
REQ-004 Write-data ports SHALL be: wdata in DATA_W; wdata_valid in 1; wdata_ready out 1, capture pulse.
REQ-005 Read-data ports SHALL be: rdata out DATA_W; rdata_valid out 1, one-cycle pulse.
REQ-006 Status ports SHALL be: done out 1, success pulse; err out 1, failure pulse; split out 1, level; busy out 1.
REQ-007 Arbiter ports SHALL be: arb_req out 1; arb_grant in 1.
REQ-008 Bus ports SHALL be: bus_out out 1; bus_out_valid out 1; bus_mode out 1, 1=data 0=address; bus_rw out 1; bus_in in 1; bus_in_valid in 1; tgt_ack in 1; tgt_split in 1.

Function
REQ-009 FSM states SHALL be IDLE, ARB, ADDR, WDATA, RDATA, ACK, SPLIT; all outputs SHALL be registered.
REQ-010 req_ready SHALL be 1 only in IDLE; handshake in cycle N SHALL latch addr, rw, len, enter ARB, and assert arb_req and busy from N+1.
REQ-011 ARB: on sampled arb_grant=1 SHALL enter ADDR next cycle; arb_req SHALL stay 1 from ARB through ACK.
REQ-012 ADDR: SHALL shift ADDR_W bits LSB-first, one per cycle, with bus_out_valid=1, bus_mode=0, bus_rw=latched rw.
REQ-013 After the last address bit, the FSM SHALL go to WDATA if write, RDATA if read, with no idle cycle between.
REQ-014 WDATA: a word SHALL be captured when wdata_valid=1 and the shifter is empty, pulsing wdata_ready the same cycle; DATA_W bits SHALL be shifted LSB-first with bus_mode=1.
REQ-015 WDATA stall: while no word is available, bus_out_valid SHALL be 0 and the beat count SHALL hold.
REQ-016 RDATA: bus_mode SHALL be 1 and bus_out_valid 0; each bus_in_valid=1 cycle SHALL store bus_in at the current bit index LSB-first.
REQ-017 RDATA: the DATA_W-th bit SHALL present the word on rdata with a one-cycle rdata_valid pulse the next cycle.
REQ-018 Beat counter: after beat len+1 the FSM SHALL enter ACK.
REQ-019 ACK: tgt_ack=1 SHALL pulse done, deassert arb_req and busy, and return to IDLE next cycle.
REQ-020 tgt_split=1 in RDATA or ACK SHALL enter SPLIT, saving state, beat and bit indices; in SPLIT, split=1 and arb_req=0.
REQ-021 Leaving SPLIT: tgt_split falling SHALL re-raise arb_req; the next arb_grant=1 SHALL resume the saved state at the saved beat and bit; split SHALL clear on resume.
REQ-022 Watchdog: TIMEOUT consecutive cycles in ACK without tgt_ack, or in RDATA without bus_in_valid, SHALL pulse err and return to IDLE; any progress SHALL reload the counter.
REQ-023 arb_grant=0 during ADDR or WDATA SHALL pulse err, drop arb_req, and return to IDLE; a partial word SHALL be discarded.
REQ-024 tgt_ack and tgt_split both 1 in ACK: tgt_ack SHALL win.
REQ-025 done, err and rdata_valid SHALL never assert in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE with all outputs 0 except req_ready=1; counters, shifters and rdata SHALL clear.
REQ-027 Reset mid-transaction SHALL discard the transaction; no done or err pulse SHALL follow.

Verification
REQ-028 Write, len=0, addr 0x1234, wdata 0xA5, grant and ack immediate -> 16 addr bits LSB-first (0,0,1,0,1,1,0,0,...), then 8 data bits 1,0,1,0,0,1,0,1; then done single pulse.
REQ-029 Read burst, len=3, target returns 0x11,0x22,0x33,0x44 -> four rdata_valid pulses with those values in order; then done.
REQ-030 Read with split after beat 1 of 4, tgt_split held 10 cycles, re-grant -> split=1 and arb_req=0 during hold; resumes at beat 2; four words total; done.
REQ-031 Write burst len=1, wdata_valid withheld 5 cycles between words -> bus_out_valid=0 for those 5 cycles; 2 wdata_ready pulses; done.
REQ-032 TIMEOUT=8, no tgt_ack -> err pulse 8 cycles after ACK entry; IDLE with req_ready=1.
REQ-033 rst_n asserted mid-ADDR -> all outputs 0 at once except req_ready=1; no done or err after release.
